jk_bank_sequencer: RTL
======================

// Module: jk_bank_sequencer
// PURPOSE
//  Controller for a bank of N gate-level master-slave JK flip-flops. Turns a debounced push-button
//  step (or an optional auto-tick) into a clean J/K setup -> clock pulse -> release -> check sequence.
//  Tracks expected bank state and flags mismatches against the bank's q outputs.
//  Sits between board switches/keys and the JK bank; drives the bank's J, K and clock inputs.
// PARAMETERS
//  N           4           number of JK cells in the bank
//  DEB_CYCLES  16          cycles key must stay stable to be accepted (board build: 1_000_000)
//  PULSE_W     2           cycles jk_clk is held high (master transparent)
//  AUTO_DIV    50_000_000  clk cycles between auto-ticks (used only with JK_SEQ_AUTO_EN)
// PORTS
//  clk       in   1  system clock; single clock domain
//  rst       in   1  synchronous, active-high reset
//  key       in   1  raw push-button, active-low, asynchronous to clk
//  mode      in   2  command: 00 hold, 01 reset (J=0,K=1), 10 set (J=1,K=0), 11 toggle (J=K=1)
//  sel       in   N  per-cell enable; cells with sel=0 receive hold (J=K=0)
//  auto_en   in   1  enable auto-tick stepping (ignored without JK_SEQ_AUTO_EN)
//  q_fb      in   N  q outputs of the JK bank
//  j, k      out  N  J/K drive to the bank
//  jk_clk    out  1  clock to the bank (master captures while high, slave updates on fall)
//  busy      out  1  high while a step is in progress
//  done      out  1  one-cycle pulse at end of each step
//  err       out  1  sticky: q_fb mismatch on a valid bit
//  overrun   out  1  sticky: trigger arrived while busy
//  step_cnt  out  8  completed steps, wraps 255->0
// BEHAVIOUR
//  - Reset: j=k=0, jk_clk=0, busy=done=err=overrun=0, step_cnt=0, exp=0, exp_valid=0, FSM IDLE,
//    debouncer stable state = released. Reset mid-step aborts immediately; jk_clk drops the same edge.
//  - key passes a 2-FF synchroniser, then the debouncer; trigger = one-cycle pulse on accepted press.
//  - FSM: IDLE -> SETUP (1 cyc) -> PULSE (PULSE_W cyc) -> RELEASE (1 cyc) -> CHECK (1 cyc) -> IDLE.
//  - mode and sel are registered on the trigger cycle; later changes do not affect the current step.
//  - SETUP: j/k driven, jk_clk=0. PULSE: jk_clk=1, j/k held. RELEASE: jk_clk=0, j/k held.
//    CHECK: j=k=0; compare, then done=1 and step_cnt++.
//  - Latency: trigger at cycle T -> jk_clk high T+2..T+1+PULSE_W -> done at T+3+PULSE_W.
//    busy high SETUP..CHECK inclusive.
//  - Expected model, updated on entry to CHECK for selected bits only:
//    set -> exp=1, valid=1; reset -> exp=0, valid=1; toggle -> exp=~exp, valid unchanged; hold -> no change.
//    Bank has no reset, so bits are invalid until first set or reset.
//  - Check: err set if any bit has valid=1 and q_fb!=exp. q_fb is sampled in CHECK (bank settled).
//  - Trigger while busy: dropped, not queued; overrun=1. Key trigger and auto-tick on the same cycle
//    count as one trigger.
// CONFIGURATION
//  JK_SEQ_AUTO_EN defined:
//   - Free-running divider emits a tick every AUTO_DIV cycles while auto_en=1; tick acts as a trigger.
//   - Divider clears when auto_en=0 or on rst.
//  JK_SEQ_AUTO_EN undefined:
//   - No divider logic; auto_en is unused; key is the only trigger source.
// STRUCTURE
//  - Package jk_seq_pkg: mode encodings (CMD_HOLD/RESET/SET/TOGGLE), FSM state enum,
//    and a function cmd_to_jk(mode) returning {J,K}.
//  - Sub-module jk_key_debounce (synchroniser + stable counter + press pulse), parameterised by DEB_CYCLES.
//  - FSM, expected model and optional auto divider live in jk_bank_sequencer.
// TESTING (bench models the JK bank behaviourally on j/k/jk_clk; DEB_CYCLES=16, PULSE_W=2)
//  1. rst, press key mode=10 sel=1111 -> j=1111,k=0000 at T+1; jk_clk high T+2..T+3;
//     done at T+5; q=1111; err=0; step_cnt=1.
//  2. key bounce: 5 toggles each <16 cyc then steady press -> exactly one step; step_cnt +1.
//  3. after set-all, 3 presses mode=11 sel=0101 -> q=1010; exp matches; err=0.
//  4. press during PULSE of a step -> overrun=1, no second jk_clk pulse, step_cnt +1 only.
//  5. force bank bit0 stuck at 0, mode=10 sel=0001 -> err=1 after CHECK; stays 1 until rst.
//  6. JK_SEQ_AUTO_EN, AUTO_DIV=40, auto_en=1, mode=11 sel=0001 after set -> bit0 toggles every 40 cyc;
//     rst mid-PULSE -> jk_clk=0 next cycle, busy=0, step_cnt=0.

Source files
------------

// File: rtl/jk_seq_pkg.sv
// Shared definitions for the JK bank sequencer: command encodings, FSM states
// and the command-to-J/K mapping used when driving the bank.
package jk_seq_pkg;

    typedef enum logic [1:0] {
        CMD_HOLD   = 2'b00,
        CMD_RESET  = 2'b01,
        CMD_SET    = 2'b10,
        CMD_TOGGLE = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_PULSE   = 3'd2,
        ST_RELEASE = 3'd3,
        ST_CHECK   = 3'd4
    } state_e;

    // Returns {J,K} for a selected cell under the given command.
    function automatic logic [1:0] cmd_to_jk(input cmd_e cmd);
        logic [1:0] jk;
        case (cmd)
            CMD_RESET:  jk = 2'b01;
            CMD_SET:    jk = 2'b10;
            CMD_TOGGLE: jk = 2'b11;
            default:    jk = 2'b00;
        endcase
        return jk;
    endfunction

endpackage

// File: rtl/jk_key_debounce.sv
// Push-button front end: two-flop synchroniser for the asynchronous active-low
// key, a stability counter, and a one-cycle pulse when a press is accepted.
module jk_key_debounce
    import jk_seq_pkg::*;
#(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic press
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    logic             pressed;

    // A new level is accepted only after it differs from the stable state for
    // DEB_CYCLES consecutive cycles; any return to the stable level restarts it.
    always_comb begin
        sync1_d  = key;
        sync2_d  = sync1_q;
        pressed  = ~sync2_q;
        stable_d = stable_q;
        cnt_d    = '0;
        press_d  = 1'b0;
        if (pressed != stable_q) begin
            if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
                stable_d = pressed;
                press_d  = pressed;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Synchroniser and debounce state; reset leaves the key seen as released.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/jk_bank_sequencer.sv
// Sequencer for a bank of master-slave JK cells. Each trigger runs
// SETUP -> PULSE -> RELEASE -> CHECK, tracks the expected bank contents and
// flags mismatches on bits that have been set or reset at least once.
// Optional auto-tick stepping is compiled in with `define JK_SEQ_AUTO_EN.
module jk_bank_sequencer
    import jk_seq_pkg::*;
#(
    parameter int N          = 4,
    parameter int DEB_CYCLES = 16,
    parameter int PULSE_W    = 2,
    parameter int AUTO_DIV   = 50_000_000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key,
    input  logic [1:0]   mode,
    input  logic [N-1:0] sel,
    input  logic         auto_en,
    input  logic [N-1:0] q_fb,
    output logic [N-1:0] j,
    output logic [N-1:0] k,
    output logic         jk_clk,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic         overrun,
    output logic [7:0]   step_cnt
);

    localparam int PW_W = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;

    logic key_press;
    logic trigger;

    jk_key_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_debounce (
        .clk  (clk),
        .rst  (rst),
        .key  (key),
        .press(key_press)
    );

`ifdef JK_SEQ_AUTO_EN
    localparam int DIV_W = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick;

    // Free-running divider producing one tick every AUTO_DIV cycles while enabled.
    always_comb begin
        div_d = div_q;
        tick  = 1'b0;
        if (!auto_en) begin
            div_d = '0;
        end else if (div_q == DIV_W'(AUTO_DIV - 1)) begin
            div_d = '0;
            tick  = 1'b1;
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    // Divider register, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign trigger = key_press | tick;
`else
    localparam int unused_auto_div = AUTO_DIV;
    logic unused_auto_en;

    assign unused_auto_en = auto_en;
    assign trigger        = key_press;
`endif

    state_e          state_q, state_d;
    logic [PW_W-1:0] pulse_cnt_q, pulse_cnt_d;
    cmd_e            mode_q, mode_d;
    logic [N-1:0]    sel_q, sel_d;
    logic [N-1:0]    exp_q, exp_d;
    logic [N-1:0]    valid_q, valid_d;
    logic [N-1:0]    j_q, j_d;
    logic [N-1:0]    k_q, k_d;
    logic            jk_clk_q, jk_clk_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            overrun_q, overrun_d;
    logic [7:0]      step_cnt_q, step_cnt_d;
    logic [1:0]      jk_bits;
    logic            drive;

    // Next-state logic, expected-state model, checking and the bank drive.
    // Outputs are decoded from the next state and registered so the bank
    // clock comes straight from a flop.
    always_comb begin
        state_d     = state_q;
        pulse_cnt_d = pulse_cnt_q;
        mode_d      = mode_q;
        sel_d       = sel_q;
        exp_d       = exp_q;
        valid_d     = valid_q;
        err_d       = err_q;
        overrun_d   = overrun_q;
        step_cnt_d  = step_cnt_q;
        jk_bits     = 2'b00;
        drive       = 1'b0;
        j_d         = '0;
        k_d         = '0;
        jk_clk_d    = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    mode_d  = cmd_e'(mode);
                    sel_d   = sel;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                pulse_cnt_d = '0;
                state_d     = ST_PULSE;
            end
            ST_PULSE: begin
                if (pulse_cnt_q == PW_W'(PULSE_W - 1)) begin
                    state_d = ST_RELEASE;
                end else begin
                    pulse_cnt_d = pulse_cnt_q + PW_W'(1);
                end
            end
            ST_RELEASE: begin
                state_d = ST_CHECK;
                case (mode_q)
                    CMD_SET: begin
                        exp_d   = exp_q | sel_q;
                        valid_d = valid_q | sel_q;
                    end
                    CMD_RESET: begin
                        exp_d   = exp_q & ~sel_q;
                        valid_d = valid_q | sel_q;
                    end
                    CMD_TOGGLE: begin
                        exp_d = exp_q ^ sel_q;
                    end
                    default: begin
                        exp_d = exp_q;
                    end
                endcase
            end
            ST_CHECK: begin
                if (|(valid_q & (q_fb ^ exp_q))) begin
                    err_d = 1'b1;
                end
                step_cnt_d = step_cnt_q + 8'd1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (trigger && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end

        jk_bits  = cmd_to_jk(mode_d);
        drive    = (state_d == ST_SETUP) || (state_d == ST_PULSE) ||
                   (state_d == ST_RELEASE);
        j_d      = drive ? (sel_d & {N{jk_bits[1]}}) : '0;
        k_d      = drive ? (sel_d & {N{jk_bits[0]}}) : '0;
        jk_clk_d = (state_d == ST_PULSE);
        busy_d   = (state_d != ST_IDLE);
        done_d   = (state_d == ST_CHECK);
    end

    // Sequencer registers; reset aborts any step and drops the bank clock at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pulse_cnt_q <= '0;
            mode_q      <= CMD_HOLD;
            sel_q       <= '0;
            exp_q       <= '0;
            valid_q     <= '0;
            err_q       <= 1'b0;
            overrun_q   <= 1'b0;
            step_cnt_q  <= 8'd0;
            j_q         <= '0;
            k_q         <= '0;
            jk_clk_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pulse_cnt_q <= pulse_cnt_d;
            mode_q      <= mode_d;
            sel_q       <= sel_d;
            exp_q       <= exp_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            overrun_q   <= overrun_d;
            step_cnt_q  <= step_cnt_d;
            j_q         <= j_d;
            k_q         <= k_d;
            jk_clk_q    <= jk_clk_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign j        = j_q;
    assign k        = k_q;
    assign jk_clk   = jk_clk_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign overrun  = overrun_q;
    assign step_cnt = step_cnt_q;

endmodule
